nic_fifo: RTL and testbench

Parametrised network interface controller between a processing element (PE) and its local router port. It generalises the single-slot NIC to configurable data width and independent input/output FIFOs of configurable depth. It keeps the same 2-bit PE register map and the same virtual-channel (VC) polarity gating toward the router. Ready/send handshakes on both network sides are occupancy-driven, so the PE and router can stream back-to-back packets without stalling on a single buffer.

---
 rtl/nic_fifo.sv | 135 +++++++++++++
 tb/tb_nic_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nic_fifo.sv
// nic_fifo: network interface between a processing element and its router
// port, with an input FIFO (router -> PE) and an output FIFO (PE -> router).
// PE register map: 00 input data, 01 input status, 10 output data,
// 11 output status.
// Optional feature macro: NIC_STATUS_CNT_EN adds FIFO occupancy counts to the
// status words (bits [clog2(DEPTH)+1:1]); without it only bit 0 is returned.
module nic_fifo #(
  parameter int DATA_W    = 64,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic [DATA_W-1:0] net_di,
  input  logic              net_si,
  output logic              net_ri,
  output logic [DATA_W-1:0] net_do,
  output logic              net_so,
  input  logic              net_ro,
  input  logic              net_polarity,
  output logic              in_status,
  output logic              out_status,
  output logic              buff_en
);

  localparam int IW = $clog2(IN_DEPTH);
  localparam int OW = $clog2(OUT_DEPTH);
  localparam logic [IW:0] IN_ONE  = 1;
  localparam logic [OW:0] OUT_ONE = 1;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [IW:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OW:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;

  logic [DATA_W-1:0] in_mem_q  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem_q [OUT_DEPTH];

  logic in_empty, in_full, out_empty, out_full;
  logic in_push, in_pop, out_push, out_pop;
  logic [DATA_W-1:0] out_head;
  logic [DATA_W-1:0] in_word, out_word;

  // FIFO flags, router-side handshakes and PE-side accept strobes.
  always_comb begin
    in_empty  = (in_wr_q == in_rd_q);
    in_full   = (in_wr_q[IW] != in_rd_q[IW]) &&
                (in_wr_q[IW-1:0] == in_rd_q[IW-1:0]);
    out_empty = (out_wr_q == out_rd_q);
    out_full  = (out_wr_q[OW] != out_rd_q[OW]) &&
                (out_wr_q[OW-1:0] == out_rd_q[OW-1:0]);

    // Qualifying with the reset input keeps the router from pushing and the
    // PE from seeing strobes while the block is held in reset.
    net_ri    = reset && !in_full;
    in_status = !in_empty;
    in_push   = net_si && net_ri;
    in_pop    = reset && nicEn && !nicWrEn && (addr == 2'b00) && !in_empty;

    out_head   = out_mem_q[out_rd_q[OW-1:0]];
    out_status = out_full;
    net_do     = out_empty ? '0 : out_head;
    net_so     = !out_empty && net_ro && (out_head[DATA_W-1] != net_polarity);
    out_pop    = net_so;
    // A full output FIFO still accepts a write when a send frees a slot.
    buff_en    = reset && nicEn && nicWrEn && (addr == 2'b10) &&
                 (!out_full || net_so);
    out_push   = buff_en;
  end

  // Status words returned on addr 01 / 11.
  always_comb begin
    in_word     = '0;
    out_word    = '0;
    in_word[0]  = in_status;
    out_word[0] = out_status;
`ifdef NIC_STATUS_CNT_EN
    in_word[IW+1:1]  = in_wr_q - in_rd_q;
    out_word[OW+1:1] = out_wr_q - out_rd_q;
`endif
  end

  // PE read mux; reads of addr 10, idle cycles and reset all return zero.
  always_comb begin
    d_out = '0;
    if (reset && nicEn && !nicWrEn) begin
      case (addr)
        2'b00:   d_out = in_mem_q[in_rd_q[IW-1:0]];
        2'b01:   d_out = in_word;
        2'b11:   d_out = out_word;
        default: d_out = '0;
      endcase
    end
  end

  // Next pointer values; simultaneous push and pop keep occupancy unchanged.
  always_comb begin
    in_wr_d  = in_wr_q;
    in_rd_d  = in_rd_q;
    out_wr_d = out_wr_q;
    out_rd_d = out_rd_q;
    if (in_push)  in_wr_d  = in_wr_q + IN_ONE;
    if (in_pop)   in_rd_d  = in_rd_q + IN_ONE;
    if (out_push) out_wr_d = out_wr_q + OUT_ONE;
    if (out_pop)  out_rd_d = out_rd_q + OUT_ONE;
  end

  // Pointer registers; reset empties both FIFOs immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_q  <= '0;
      in_rd_q  <= '0;
      out_wr_q <= '0;
      out_rd_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      in_wr_q  <= in_wr_d;
      in_rd_q  <= in_rd_d;
      out_wr_q <= out_wr_d;
      out_rd_q <= out_rd_d;
    end
  end

  // FIFO storage writes at the write pointer.
  // NOTE: storage is deliberately not reset; empty pointers make it invisible.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q[IW-1:0]]   <= net_di;
    if (out_push) out_mem_q[out_wr_q[OW-1:0]] <= d_in;
  end

endmodule

// File: tb/tb_nic_fifo.sv
// Self-checking bench for nic_fifo: directed vector table, hand-written
// corner sequences (output full/bypass, input full, async reset) and a
// randomized phase against a queue-based reference model.
module tb_nic_fifo;
  localparam int DW = 64;
  localparam int ID = 4;
  localparam int OD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          nic_en, nic_wr_en;
  logic [1:0]    addr;
  logic [DW-1:0] d_in, d_out, net_di, net_do;
  logic          net_si, net_ri, net_so, net_ro, net_polarity;
  logic          in_status, out_status, buff_en;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nic_fifo #(.DATA_W(DW), .IN_DEPTH(ID), .OUT_DEPTH(OD)) dut (
    .clk(clk), .reset(reset), .nicEn(nic_en), .nicWrEn(nic_wr_en),
    .addr(addr), .d_in(d_in), .d_out(d_out), .net_di(net_di),
    .net_si(net_si), .net_ri(net_ri), .net_do(net_do), .net_so(net_so),
    .net_ro(net_ro), .net_polarity(net_polarity), .in_status(in_status),
    .out_status(out_status), .buff_en(buff_en)
  );

  typedef struct {
    logic        en, wr;
    logic [1:0]  a;
    logic [63:0] din, ndi;
    logic        nsi, nro, pol;
    logic [63:0] e_dout, e_ndo;
    logic        e_ri, e_so, e_ist, e_ost, e_ben;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] st(input int cnt, input logic flag);
`ifdef NIC_STATUS_CNT_EN
    return (64'(cnt) << 1) | 64'(flag);
`else
    return 64'(flag) | 64'(cnt & 0);
`endif
  endfunction

  task automatic set_in(input logic en, input logic wr, input logic [1:0] a,
                        input logic [63:0] din, input logic [63:0] ndi,
                        input logic nsi, input logic nro, input logic pol);
    nic_en = en; nic_wr_en = wr; addr = a; d_in = din; net_di = ndi;
    net_si = nsi; net_ro = nro; net_polarity = pol;
  endtask

  task automatic idle(input logic pol);
    set_in(1'b0, 1'b0, 2'b00, 64'd0, 64'd0, 1'b0, 1'b1, pol);
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input string tag, input logic [63:0] e_dout,
                           input logic [63:0] e_ndo, input logic e_ri,
                           input logic e_so, input logic e_ist,
                           input logic e_ost, input logic e_ben);
    check({tag, "_d_out"},      d_out,      e_dout);
    check({tag, "_net_do"},     net_do,     e_ndo);
    check({tag, "_net_ri"},     64'(net_ri),     64'(e_ri));
    check({tag, "_net_so"},     64'(net_so),     64'(e_so));
    check({tag, "_in_status"},  64'(in_status),  64'(e_ist));
    check({tag, "_out_status"}, 64'(out_status), 64'(e_ost));
    check({tag, "_buff_en"},    64'(buff_en),    64'(e_ben));
  endtask

  logic [63:0] in_q[$];
  logic [63:0] out_q[$];

  initial begin
    // Directed vectors: all with net_ro=1, net_polarity=1.
    vecs[0]  = '{1'b1,1'b1,2'd2,64'd1234,64'd0,1'b0,1'b1,1'b1, 64'd0,64'd0,1'b1,1'b0,1'b0,1'b0,1'b1};
    vecs[1]  = '{1'b0,1'b0,2'd0,64'd0,64'd0,1'b0,1'b1,1'b1,    64'd0,64'd1234,1'b1,1'b1,1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b0,2'd0,64'd0,64'd0,1'b0,1'b1,1'b1,    64'd0,64'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b0,2'd0,64'd0,64'd1314,1'b1,1'b1,1'b1, 64'd0,64'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b0,2'd0,64'd0,64'd1492,1'b1,1'b1,1'b1, 64'd0,64'd0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,2'd0,64'd0,64'd1738,1'b1,1'b1,1'b1, 64'd0,64'd0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b1,1'b0,2'd1,64'd0,64'd0,1'b0,1'b1,1'b1,    st(3,1'b1),64'd0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b1,1'b0,2'd0,64'd0,64'd0,1'b0,1'b1,1'b1,    64'd1314,64'd0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[8]  = '{1'b1,1'b0,2'd0,64'd0,64'd0,1'b0,1'b1,1'b1,    64'd1492,64'd0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b0,2'd0,64'd0,64'd0,1'b0,1'b1,1'b1,    64'd1738,64'd0,1'b1,1'b0,1'b1,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,2'd3,64'd0,64'd0,1'b0,1'b1,1'b1,    st(0,1'b0),64'd0,1'b1,1'b0,1'b0,1'b0,1'b0};
    vecs[11] = '{1'b1,1'b0,2'd2,64'd0,64'd0,1'b0,1'b1,1'b1,    64'd0,64'd0,1'b1,1'b0,1'b0,1'b0,1'b0};

    // Reset held low for two cycles.
    reset = 1'b0;
    idle(1'b1);
    @(negedge clk);
    check_all("rst_a", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_all("rst_b", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst_release_net_ri", 64'(net_ri), 64'd1);
    step;

    // Table-driven directed vectors.
    for (int i = 0; i < 12; i++) begin
      set_in(vecs[i].en, vecs[i].wr, vecs[i].a, vecs[i].din, vecs[i].ndi,
             vecs[i].nsi, vecs[i].nro, vecs[i].pol);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_ndo,
                vecs[i].e_ri, vecs[i].e_so, vecs[i].e_ist, vecs[i].e_ost,
                vecs[i].e_ben);
      step;
    end

    // Output FIFO: fill while VC is blocked, drop one write, then a send
    // and a write in the same cycle on a full FIFO.
    for (int i = 0; i < OD; i++) begin
      set_in(1'b1, 1'b1, 2'd2, 64'(100 + i), 64'd0, 1'b0, 1'b1, 1'b0);
      #1;
      check("ofill_buff_en", 64'(buff_en), 64'd1);
      check("ofill_net_so", 64'(net_so), 64'd0);
      step;
    end
    set_in(1'b1, 1'b1, 2'd2, 64'd150, 64'd0, 1'b0, 1'b1, 1'b0);
    #1;
    check("ofull_out_status", 64'(out_status), 64'd1);
    check("ofull_drop_buff_en", 64'(buff_en), 64'd0);
    step;
    set_in(1'b1, 1'b1, 2'd2, 64'd200, 64'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check("obypass_net_so", 64'(net_so), 64'd1);
    check("obypass_buff_en", 64'(buff_en), 64'd1);
    check("obypass_net_do", net_do, 64'd100);
    step;
    begin
      logic [63:0] exp_seq[4];
      exp_seq[0] = 64'd101; exp_seq[1] = 64'd102;
      exp_seq[2] = 64'd103; exp_seq[3] = 64'd200;
      for (int i = 0; i < 4; i++) begin
        idle(1'b1);
        #1;
        if (i == 0) check("obypass_still_full", 64'(out_status), 64'd1);
        check($sformatf("odrain%0d_net_do", i), net_do, exp_seq[i]);
        check($sformatf("odrain%0d_net_so", i), 64'(net_so), 64'd1);
        step;
      end
    end
    idle(1'b1);
    #1;
    check("odrain_empty_net_so", 64'(net_so), 64'd0);
    check("odrain_empty_net_do", net_do, 64'd0);

    // Input FIFO: fill, ignored push while full, no bypass on pop.
    for (int i = 0; i < ID; i++) begin
      set_in(1'b0, 1'b0, 2'd0, 64'd0, 64'(500 + i), 1'b1, 1'b1, 1'b1);
      #1;
      check("ifill_net_ri", 64'(net_ri), 64'd1);
      step;
    end
    set_in(1'b0, 1'b0, 2'd0, 64'd0, 64'd999, 1'b1, 1'b1, 1'b1);
    #1;
    check("ifull_net_ri", 64'(net_ri), 64'd0);
    check("ifull_in_status", 64'(in_status), 64'd1);
    step;
    set_in(1'b1, 1'b0, 2'd0, 64'd0, 64'd777, 1'b1, 1'b1, 1'b1);
    #1;
    check("ipop_full_net_ri", 64'(net_ri), 64'd0);
    check("ipop_full_d_out", d_out, 64'd500);
    step;
    idle(1'b1);
    #1;
    check("ipop_after_net_ri", 64'(net_ri), 64'd1);
    for (int i = 1; i < ID; i++) begin
      set_in(1'b1, 1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
      #1;
      check($sformatf("idrain%0d_d_out", i), d_out, 64'(500 + i));
      step;
    end
    idle(1'b1);
    #1;
    check("idrain_empty_in_status", 64'(in_status), 64'd0);

    // Asynchronous reset with both FIFOs holding data.
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 1'b1, 2'd2, 64'(300 + i), 64'(600 + i), 1'b1, 1'b1, 1'b0);
      step;
    end
    set_in(1'b1, 1'b1, 2'd2, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    #1;
    check("prerst_net_so", 64'(net_so), 64'd1);
    check("prerst_in_status", 64'(in_status), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check_all("midrst", 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1);
    #1;
    check("midrst_read_d_out", d_out, 64'd0);
    check("midrst_push_net_ri", 64'(net_ri), 64'd0);
    step;
    step;
    idle(1'b1);
    reset = 1'b1;
    #1;
    check_all("postrst", 64'd0, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step;

    // Randomized phase against a queue model.
    in_q.delete();
    out_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic en, wr, nsi, nro, pol;
      logic [1:0] a;
      logic [63:0] din, ndi, head, e_dout;
      logic e_ri, e_so, e_ben, chk_dout;
      en  = ($urandom_range(0, 2) != 0);
      wr  = $urandom_range(0, 1) == 1;
      a   = 2'($urandom_range(0, 3));
      din = {$urandom, $urandom};
      ndi = {$urandom, $urandom};
      nsi = ($urandom_range(0, 2) != 0);
      nro = ($urandom_range(0, 3) != 0);
      pol = $urandom_range(0, 1) == 1;
      set_in(en, wr, a, din, ndi, nsi, nro, pol);

      e_ri  = (in_q.size() < ID);
      head  = (out_q.size() > 0) ? out_q[0] : 64'd0;
      e_so  = (out_q.size() > 0) && nro && (head[63] != pol);
      e_ben = en && wr && (a == 2'd2) && ((out_q.size() < OD) || e_so);
      e_dout   = 64'd0;
      chk_dout = 1'b1;
      if (en && !wr) begin
        case (a)
          2'd0: if (in_q.size() > 0) e_dout = in_q[0]; else chk_dout = 1'b0;
          2'd1: e_dout = st(in_q.size(), in_q.size() > 0);
          2'd3: e_dout = st(out_q.size(), out_q.size() == OD);
          default: e_dout = 64'd0;
        endcase
      end
      #1;
      check("rnd_net_ri", 64'(net_ri), 64'(e_ri));
      check("rnd_in_status", 64'(in_status), 64'(in_q.size() > 0));
      check("rnd_out_status", 64'(out_status), 64'(out_q.size() == OD));
      check("rnd_net_so", 64'(net_so), 64'(e_so));
      check("rnd_net_do", net_do, head);
      check("rnd_buff_en", 64'(buff_en), 64'(e_ben));
      if (chk_dout) check("rnd_d_out", d_out, e_dout);

      if (en && !wr && a == 2'd0 && in_q.size() > 0) void'(in_q.pop_front());
      if (nsi && e_ri) in_q.push_back(ndi);
      if (e_so) void'(out_q.pop_front());
      if (e_ben) out_q.push_back(din);
      step;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
